// File: rtl/uart_core_p.sv
// UART core: 16x oversampling baud generator, RX/TX frame engines with optional
// parity, first-word-fall-through RX/TX FIFOs and sticky receive error flags.
module uart_fifo_p #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] w,
  output logic [W-1:0] r,
  output logic         empty,
  output logic         full
);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [2**AW];
  logic [AW:0]  wp_r;
  logic [AW:0]  rp_r;
  logic         do_wr_s;
  logic         do_rd_s;

  assign empty   = (wp_r == rp_r);
  assign full    = (wp_r[AW] != rp_r[AW]) && (wp_r[AW-1:0] == rp_r[AW-1:0]);
  assign do_rd_s = rd && !empty;
  assign do_wr_s = wr && (!full || rd);
  assign r       = empty ? '0 : mem_r[rp_r[AW-1:0]];

  // pointer update; the extra MSB tells full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_r <= '0;
      rp_r <= '0;
    end else begin
      if (do_wr_s) wp_r <= wp_r + PTR_ONE;
      if (do_rd_s) rp_r <= rp_r + PTR_ONE;
    end
  end

  // storage array, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_r[wp_r[AW-1:0]] <= w;
  end
endmodule

module uart_core_p #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_W     = 2,
  parameter int DVSR_W     = 11,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  output logic              tx_full,
  output logic              tx,
  output logic              tick,
  input  logic              clr_err,
  output logic              err_frame,
  output logic              err_parity,
  output logic              err_overrun
);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  localparam logic [DVSR_W-1:0] CNT_ONE = {{(DVSR_W-1){1'b0}}, 1'b1};
  localparam logic [4:0] S_HALF  = 5'd7;
  localparam logic [4:0] S_LAST  = 5'd15;
  localparam logic [4:0] S_STOP  = 5'(SB_TICK - 1);
  localparam logic [3:0] N_LAST  = 4'(DBIT - 1);
  localparam bit         HAS_PAR = (PARITY_EN != 0);

  function automatic logic par_bit(input logic [DBIT-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic [DVSR_W-1:0] cnt_r;
  logic              tick_r;
  logic [1:0]        sync_r;
  logic              rx_sync_s;

  // baud tick generator; >= makes a lowered divisor wrap immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r >= dvsr) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      tick_r <= 1'b0;
    end
  end
  assign tick = tick_r;

  // two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_r <= 2'b11;
    else          sync_r <= {sync_r[0], rx};
  end
  assign rx_sync_s = sync_r[1];

  state_t          rx_st_r;
  logic [4:0]      rx_tk_r;
  logic [3:0]      rx_n_r;
  logic [DBIT-1:0] rx_b_r;
  logic            rx_push_r;
  logic            fe_ev_r;
  logic            pe_ev_r;
  logic            rx_full_s;

  // receive frame engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st_r <= ST_IDLE; rx_tk_r <= '0; rx_n_r <= '0; rx_b_r <= '0;
      rx_push_r <= 1'b0; fe_ev_r <= 1'b0; pe_ev_r <= 1'b0;
    end else begin
      rx_push_r <= 1'b0; fe_ev_r <= 1'b0; pe_ev_r <= 1'b0;
      case (rx_st_r)
        ST_IDLE: if (!rx_sync_s) begin rx_st_r <= ST_START; rx_tk_r <= '0; end
        ST_START: if (tick_r) begin
          if (rx_tk_r == S_HALF) begin
            rx_tk_r <= '0; rx_n_r <= '0;
            rx_st_r <= rx_sync_s ? ST_IDLE : ST_DATA;
          end else rx_tk_r <= rx_tk_r + 5'd1;
        end
        ST_DATA: if (tick_r) begin
          if (rx_tk_r == S_LAST) begin
            rx_tk_r <= '0;
            rx_b_r  <= {rx_sync_s, rx_b_r[DBIT-1:1]};
            if (rx_n_r == N_LAST) rx_st_r <= HAS_PAR ? ST_PAR : ST_STOP;
            else                  rx_n_r  <= rx_n_r + 4'd1;
          end else rx_tk_r <= rx_tk_r + 5'd1;
        end
        ST_PAR: if (tick_r) begin
          if (rx_tk_r == S_LAST) begin
            rx_tk_r <= '0;
            pe_ev_r <= (rx_sync_s != par_bit(rx_b_r));
            rx_st_r <= ST_STOP;
          end else rx_tk_r <= rx_tk_r + 5'd1;
        end
        ST_STOP: if (tick_r) begin
          if (rx_tk_r == S_STOP) begin
            fe_ev_r <= !rx_sync_s; rx_push_r <= 1'b1; rx_st_r <= ST_IDLE;
          end else rx_tk_r <= rx_tk_r + 5'd1;
        end
        default: rx_st_r <= ST_IDLE;
      endcase
    end
  end

  uart_fifo_p #(.W(DBIT), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .wr(rx_push_r), .rd(rd_uart), .w(rx_b_r),
    .r(r_data), .empty(rx_empty), .full(rx_full_s)
  );

  // sticky error flags; a set event outranks a coincident clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_frame <= 1'b0; err_parity <= 1'b0; err_overrun <= 1'b0;
    end else begin
      err_frame   <= fe_ev_r | (err_frame & ~clr_err);
      err_parity  <= pe_ev_r | (err_parity & ~clr_err);
      err_overrun <= (rx_push_r & rx_full_s & ~rd_uart) | (err_overrun & ~clr_err);
    end
  end

  state_t          tx_st_r;
  logic [4:0]      tx_tk_r;
  logic [3:0]      tx_n_r;
  logic [DBIT-1:0] tx_b_r;
  logic [DBIT-1:0] tx_head_s;
  logic            tx_par_r;
  logic            tx_r;
  logic            tx_empty_s;
  logic            tx_pop_s;

  assign tx_pop_s = !tx_empty_s && ((tx_st_r == ST_IDLE) ||
                    ((tx_st_r == ST_STOP) && tick_r && (tx_tk_r == S_STOP)));

  // transmit frame engine; a pop always starts a new frame, even straight out of STOP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st_r <= ST_IDLE; tx_tk_r <= '0; tx_n_r <= '0; tx_b_r <= '0;
      tx_par_r <= 1'b0; tx_r <= 1'b1;
    end else if (tx_pop_s) begin
      tx_st_r <= ST_START; tx_tk_r <= '0; tx_b_r <= tx_head_s;
      tx_par_r <= par_bit(tx_head_s); tx_r <= 1'b0;
    end else begin
      case (tx_st_r)
        ST_IDLE: tx_r <= 1'b1;
        ST_START: if (tick_r) begin
          if (tx_tk_r == S_LAST) begin
            tx_tk_r <= '0; tx_n_r <= '0; tx_st_r <= ST_DATA; tx_r <= tx_b_r[0];
          end else tx_tk_r <= tx_tk_r + 5'd1;
        end
        ST_DATA: if (tick_r) begin
          if (tx_tk_r == S_LAST) begin
            tx_tk_r <= '0;
            tx_b_r  <= {1'b0, tx_b_r[DBIT-1:1]};
            if (tx_n_r == N_LAST) begin
              if (HAS_PAR) begin tx_st_r <= ST_PAR;  tx_r <= tx_par_r; end
              else         begin tx_st_r <= ST_STOP; tx_r <= 1'b1;     end
            end else begin
              tx_n_r <= tx_n_r + 4'd1; tx_r <= tx_b_r[1];
            end
          end else tx_tk_r <= tx_tk_r + 5'd1;
        end
        ST_PAR: if (tick_r) begin
          if (tx_tk_r == S_LAST) begin
            tx_tk_r <= '0; tx_st_r <= ST_STOP; tx_r <= 1'b1;
          end else tx_tk_r <= tx_tk_r + 5'd1;
        end
        ST_STOP: if (tick_r) begin
          if (tx_tk_r == S_STOP) begin tx_st_r <= ST_IDLE; tx_r <= 1'b1; end
          else tx_tk_r <= tx_tk_r + 5'd1;
        end
        default: begin tx_st_r <= ST_IDLE; tx_r <= 1'b1; end
      endcase
    end
  end
  assign tx = tx_r;

  uart_fifo_p #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .wr(wr_uart), .rd(tx_pop_s), .w(w_data),
    .r(tx_head_s), .empty(tx_empty_s), .full(tx_full)
  );
endmodule

// File: tb/tb_uart_core_p.sv
// Bench for uart_core_p: an 8N1 instance and an even-parity instance, checked
// against a queue/flag model of frames sent and a cycle-count model of tick.
`timescale 1ns/1ps
module tb_uart_core_p;
  localparam int DV  = 3;
  localparam int BIT = 16 * (DV + 1);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] dvsr = 11'd3;

  logic       rx_a = 1'b1, rd_a = 1'b0, wr_a = 1'b0, clr_a = 1'b0;
  logic [7:0] w_a = 8'h00, rdata_a;
  logic       rxe_a, txf_a, tx_a, tick_a, fe_a, pe_a, oe_a;
  logic       rx_b = 1'b1, rd_b = 1'b0, wr_b = 1'b0, clr_b = 1'b0;
  logic [7:0] w_b = 8'h00, rdata_b;
  logic       rxe_b, txf_b, tx_b, tick_b, fe_b, pe_b, oe_b;

  uart_core_p dut_a (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .rx(rx_a), .rd_uart(rd_a),
    .r_data(rdata_a), .rx_empty(rxe_a), .wr_uart(wr_a), .w_data(w_a),
    .tx_full(txf_a), .tx(tx_a), .tick(tick_a), .clr_err(clr_a),
    .err_frame(fe_a), .err_parity(pe_a), .err_overrun(oe_a));

  uart_core_p #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .rx(rx_b), .rd_uart(rd_b),
    .r_data(rdata_b), .rx_empty(rxe_b), .wr_uart(wr_b), .w_data(w_b),
    .tx_full(txf_b), .tx(tx_b), .tick(tick_b), .clr_err(clr_b),
    .err_frame(fe_b), .err_parity(pe_b), .err_overrun(oe_b));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  bit mfe[2], mpe[2], moe[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit evenpar(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += v[i];
    return bit'(c % 2);
  endfunction

  // edges since reset release; tick must fire on every (dvsr+1)-th one
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("tick_a", tick_a, (cyc > 0) && (cyc % (DV + 1) == 0));
    chk("tick_b", tick_b, (cyc > 0) && (cyc % (DV + 1) == 0));
  end

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic send_frame(input int d, input logic [7:0] v, input bit stop_ok, input bit par_ok);
    set_rx(d, 1'b0); step(BIT);
    for (int i = 0; i < 8; i++) begin set_rx(d, v[i]); step(BIT); end
    if (d == 1) begin set_rx(d, par_ok ? evenpar(v) : ~evenpar(v)); step(BIT); end
    if (stop_ok) begin set_rx(d, 1'b1); step(BIT); end
    else begin set_rx(d, 1'b0); step(48); set_rx(d, 1'b1); step(BIT - 48); end
    step(40);
    if (d == 0) begin
      if (q_a.size() < 4) q_a.push_back(v); else moe[0] = 1'b1;
    end else begin
      if (q_b.size() < 4) q_b.push_back(v); else moe[1] = 1'b1;
      if (!par_ok) mpe[1] = 1'b1;
    end
    if (!stop_ok) mfe[d] = 1'b1;
  endtask

  task automatic check_rx(input int d);
    if (d == 0) begin
      chk("rx_empty_a", rxe_a, q_a.size() == 0);
      if (q_a.size() != 0) chk("r_data_a", rdata_a, q_a[0]);
      chk("err_frame_a", fe_a, mfe[0]);
      chk("err_parity_a", pe_a, mpe[0]);
      chk("err_overrun_a", oe_a, moe[0]);
    end else begin
      chk("rx_empty_b", rxe_b, q_b.size() == 0);
      if (q_b.size() != 0) chk("r_data_b", rdata_b, q_b[0]);
      chk("err_frame_b", fe_b, mfe[1]);
      chk("err_parity_b", pe_b, mpe[1]);
      chk("err_overrun_b", oe_b, moe[1]);
    end
  endtask

  task automatic rd(input int d);
    if (d == 0) begin rd_a = 1'b1; step(); rd_a = 1'b0; if (q_a.size() != 0) void'(q_a.pop_front()); end
    else        begin rd_b = 1'b1; step(); rd_b = 1'b0; if (q_b.size() != 0) void'(q_b.pop_front()); end
    check_rx(d);
  endtask

  task automatic clr(input int d);
    if (d == 0) begin clr_a = 1'b1; step(); clr_a = 1'b0; end
    else        begin clr_b = 1'b1; step(); clr_b = 1'b0; end
    mfe[d] = 1'b0; mpe[d] = 1'b0; moe[d] = 1'b0;
    check_rx(d);
  endtask

  task automatic wr(input logic [7:0] v);
    w_a = v; wr_a = 1'b1; step(); wr_a = 1'b0;
  endtask

  // decode one 8N1 frame from tx_a by mid-bit sampling
  task automatic tx_frame(input logic [7:0] exp, input bit b2b);
    int n = 0;
    while (tx_a !== 1'b0 && n < 3000) begin step(); n++; end
    chk("tx_start_seen", n < 3000, 1);
    if (b2b) chk("tx_no_gap", n <= 36, 1);
    step(BIT / 2);
    chk("tx_start_bit", tx_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(BIT);
      chk("tx_data_bit", tx_a, exp[i]);
    end
    step(BIT);
    chk("tx_stop_bit", tx_a, 1'b1);
  endtask

  task automatic tx_idle_check();
    int z = 0;
    for (int i = 0; i < 200; i++) begin step(); if (tx_a !== 1'b1) z++; end
    chk("tx_idle", z, 0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] wq[$];
    step(3);
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_rx_empty", rxe_a, 1'b1);
    chk("rst_tx_full", txf_a, 1'b0);
    chk("rst_r_data", rdata_a, 8'h00);
    chk("rst_errs", {fe_a, pe_a, oe_a}, 3'b000);
    reset_n = 1'b1;
    chk("model_par07", evenpar(8'h07), 1'b1);
    chk("model_par55", evenpar(8'h55), 1'b0);

    // basic 8N1 receive
    send_frame(0, 8'hA5, 1'b1, 1'b1);
    check_rx(0);
    chk("a5_data", rdata_a, 8'hA5);
    chk("a5_noerr", {fe_a, pe_a, oe_a}, 3'b000);
    rd(0);

    // overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b1, 1'b1);
    check_rx(0);
    chk("ovr_flag", oe_a, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_read", rdata_a, 32'(i));
      rd(0);
    end
    chk("ovr_empty", rxe_a, 1'b1);
    clr(0);

    // framing error then a clean frame
    send_frame(0, 8'h55, 1'b0, 1'b1);
    check_rx(0);
    chk("fe_flag", fe_a, 1'b1);
    send_frame(0, 8'h12, 1'b1, 1'b1);
    check_rx(0);
    chk("fe_data", rdata_a, 8'h55);
    rd(0);
    chk("fe_next", rdata_a, 8'h12);
    rd(0);
    clr(0);

    // randomised frames, occasional bad stop bits, random draining
    for (int k = 0; k < 12; k++) begin
      v = 8'($urandom_range(0, 255));
      send_frame(0, v, $urandom_range(0, 5) != 0, 1'b1);
      check_rx(0);
      for (int r = $urandom_range(0, 2); r > 0; r--) rd(0);
      if ($urandom_range(0, 3) == 0) clr(0);
    end
    while (q_a.size() != 0) rd(0);
    clr(0);

    // even parity instance: bad parity still stores the byte
    send_frame(1, 8'h07, 1'b1, 1'b0);
    check_rx(1);
    chk("par_data", rdata_b, 8'h07);
    chk("par_flag", pe_b, 1'b1);
    clr(1);
    chk("par_clr", pe_b, 1'b0);
    rd(1);
    for (int k = 0; k < 4; k++) begin
      send_frame(1, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
      check_rx(1);
      rd(1);
    end

    // back-to-back transmit
    wr(8'h3C);
    wr(8'hC3);
    tx_frame(8'h3C, 1'b0);
    tx_frame(8'hC3, 1'b1);
    tx_idle_check();

    // TX FIFO full: sixth write is lost
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      wq.push_back(v);
      wr(v);
    end
    chk("tx_full_set", txf_a, 1'b1);
    for (int i = 0; i < 5; i++) tx_frame(wq[i], i != 0);
    tx_idle_check();
    chk("tx_full_clr", txf_a, 1'b0);

    // reset in the middle of a TX frame with RX data and a flag pending
    send_frame(0, 8'h99, 1'b0, 1'b1);
    check_rx(0);
    wr(8'hA5);
    step(20);
    chk("mid_tx_low", tx_a, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx_a, 1'b1);
    chk("rst_mid_full", txf_a, 1'b0);
    chk("rst_mid_empty", rxe_a, 1'b1);
    chk("rst_mid_rdata", rdata_a, 8'h00);
    chk("rst_mid_errs", {fe_a, pe_a, oe_a}, 3'b000);
    q_a.delete();
    mfe[0] = 1'b0; mpe[0] = 1'b0; moe[0] = 1'b0;
    step(3);
    reset_n = 1'b1;
    send_frame(0, 8'h3E, 1'b1, 1'b1);
    check_rx(0);
    wr(8'h5A);
    tx_frame(8'h5A, 1'b0);
    tx_idle_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
